// File: rtl/clock_time_ctrl.sv
// 24-hour HH:MM:SS clock with debounced mode/inc buttons and a blinking set mode; all outputs registered.
// Define CLOCK_ALARM_EN to add the SET_ALARM state, the alarm registers and the alarm compare.
module clock_time_ctrl #(
  parameter int TICKS_PER_SEC   = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 500_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  output logic [8:0] houres,
  output logic [5:0] minute,
  output logic [5:0] seconds,
  output logic [1:0] mode,
  output logic       blank_hours,
  output logic       blank_minutes,
  output logic       alarm
);

  localparam int PS_W = $clog2(TICKS_PER_SEC);
  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICKS_PER_SEC - 1);
  localparam logic [PS_W-1:0] PS_HALF = PS_W'(TICKS_PER_SEC / 2);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    SET_HOUR  = 2'd1,
    SET_MIN   = 2'd2,
    SET_ALARM = 2'd3
  } mode_e;

  function automatic logic [5:0] inc59(input logic [5:0] v);
    return (v == 6'd59) ? 6'd0 : v + 6'd1;
  endfunction

  function automatic logic [4:0] inc23(input logic [4:0] v);
    return (v == 5'd23) ? 5'd0 : v + 5'd1;
  endfunction

  // Bit 0 is the mode button, bit 1 the inc button.
  logic [1:0]      btn_raw;
  logic [1:0]      sync1_q, sync2_q, level_q, press_q;
  logic [DB_W-1:0] db_cnt_q [2];
  logic            mode_press, inc_press;

  assign btn_raw = {btn_inc, btn_mode};

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      level_q <= '0;
      press_q <= '0;
      for (int b = 0; b < 2; b++) db_cnt_q[b] <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      for (int b = 0; b < 2; b++) begin
        press_q[b] <= 1'b0;
        if (sync2_q[b] != level_q[b]) begin
          if (db_cnt_q[b] == DB_LAST) begin
            db_cnt_q[b] <= '0;
            level_q[b]  <= sync2_q[b];
            press_q[b]  <= sync2_q[b];
          end else begin
            db_cnt_q[b] <= db_cnt_q[b] + 1'b1;
          end
        end else begin
          db_cnt_q[b] <= '0;
        end
      end
    end
  end

  assign mode_press = press_q[0];
  assign inc_press  = press_q[1];

  mode_e           mode_q, mode_d;
  logic [PS_W-1:0] presc_q, presc_d;
  logic [4:0]      hours_q, hours_d;
  logic [5:0]      min_q, min_d;
  logic [5:0]      sec_q, sec_d;
  logic            phase_q, phase_d;
  logic            blank_h_q, blank_h_d;
  logic            blank_m_q, blank_m_d;
  logic            tick;
`ifdef CLOCK_ALARM_EN
  logic [4:0]      alarm_h_q, alarm_h_d;
  logic [5:0]      alarm_m_q, alarm_m_d;
  logic            dismissed_q, dismissed_d;
  logic            alarm_q, alarm_d;
  logic [4:0]      disp_h_q, disp_h_d;
  logic [5:0]      disp_m_q, disp_m_d;
`endif

  always_comb begin
    mode_d  = mode_q;
    presc_d = (presc_q == PS_LAST) ? '0 : presc_q + 1'b1;
    hours_d = hours_q;
    min_d   = min_q;
    sec_d   = sec_q;
    phase_d = phase_q;
    tick    = (mode_q == RUN) && (presc_q == PS_LAST);
`ifdef CLOCK_ALARM_EN
    alarm_h_d = alarm_h_q;
    alarm_m_d = alarm_m_q;
`endif

    // The prescaler keeps running in SET states so the blink phase stays alive.
    if (presc_q == '0 || presc_q == PS_HALF) phase_d = ~phase_q;

    if (tick && !mode_press) begin
      sec_d = inc59(sec_q);
      if (sec_q == 6'd59) begin
        min_d = inc59(min_q);
        if (min_q == 6'd59) hours_d = inc23(hours_q);
      end
    end

    if (mode_press) begin
      case (mode_q)
        RUN: begin
          mode_d  = SET_HOUR;
          sec_d   = '0;
          presc_d = '0;
        end
        SET_HOUR: mode_d = SET_MIN;
        SET_MIN: begin
`ifdef CLOCK_ALARM_EN
          mode_d = SET_ALARM;
`else
          mode_d  = RUN;
          presc_d = '0;
`endif
        end
        default: begin
          mode_d  = RUN;
          presc_d = '0;
        end
      endcase
    end else if (inc_press) begin
      case (mode_q)
        SET_HOUR: hours_d = inc23(hours_q);
        SET_MIN:  min_d   = inc59(min_q);
`ifdef CLOCK_ALARM_EN
        SET_ALARM: begin
          alarm_m_d = inc59(alarm_m_q);
          if (alarm_m_q == 6'd59) alarm_h_d = inc23(alarm_h_q);
        end
`endif
        default: ;
      endcase
    end

`ifdef CLOCK_ALARM_EN
    // A fresh minute re-arms the alarm; a press in RUN silences it for the current minute.
    dismissed_d = dismissed_q;
    if (min_d != min_q) dismissed_d = 1'b0;
    if (inc_press && !mode_press && mode_q == RUN) dismissed_d = 1'b1;

    disp_h_d = (mode_d == SET_ALARM) ? alarm_h_d : hours_d;
    disp_m_d = (mode_d == SET_ALARM) ? alarm_m_d : min_d;
    alarm_d  = (mode_d == RUN) && (hours_d == alarm_h_d) && (min_d == alarm_m_d) && !dismissed_d;
`endif

    blank_h_d = phase_d && (mode_d == SET_HOUR || mode_d == SET_ALARM);
    blank_m_d = phase_d && (mode_d == SET_MIN  || mode_d == SET_ALARM);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q      <= RUN;
      presc_q     <= '0;
      hours_q     <= '0;
      min_q       <= '0;
      sec_q       <= '0;
      phase_q     <= 1'b0;
      blank_h_q   <= 1'b0;
      blank_m_q   <= 1'b0;
`ifdef CLOCK_ALARM_EN
      alarm_h_q   <= '0;
      alarm_m_q   <= '0;
      dismissed_q <= 1'b0;
      alarm_q     <= 1'b0;
      disp_h_q    <= '0;
      disp_m_q    <= '0;
`endif
    end else begin
      mode_q      <= mode_d;
      presc_q     <= presc_d;
      hours_q     <= hours_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      phase_q     <= phase_d;
      blank_h_q   <= blank_h_d;
      blank_m_q   <= blank_m_d;
`ifdef CLOCK_ALARM_EN
      alarm_h_q   <= alarm_h_d;
      alarm_m_q   <= alarm_m_d;
      dismissed_q <= dismissed_d;
      alarm_q     <= alarm_d;
      disp_h_q    <= disp_h_d;
      disp_m_q    <= disp_m_d;
`endif
    end
  end

`ifdef CLOCK_ALARM_EN
  assign houres = {4'b0000, disp_h_q};
  assign minute = disp_m_q;
  assign alarm  = alarm_q;
`else
  assign houres = {4'b0000, hours_q};
  assign minute = min_q;
  assign alarm  = 1'b0;
`endif
  assign seconds       = sec_q;
  assign mode          = mode_q;
  assign blank_hours   = blank_h_q;
  assign blank_minutes = blank_m_q;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench for clock_time_ctrl with TICKS_PER_SEC=4, DEBOUNCE_CYCLES=3.
module tb_clock_time_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode;
  logic       btn_inc;
  logic [8:0] houres;
  logic [5:0] minute;
  logic [5:0] seconds;
  logic [1:0] mode;
  logic       blank_hours;
  logic       blank_minutes;
  logic       alarm;

  int n_checks = 0;
  int n_pass   = 0;

  clock_time_ctrl #(
    .TICKS_PER_SEC   (4),
    .DEBOUNCE_CYCLES (3)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_mode      (btn_mode),
    .btn_inc       (btn_inc),
    .houres        (houres),
    .minute        (minute),
    .seconds       (seconds),
    .mode          (mode),
    .blank_hours   (blank_hours),
    .blank_minutes (blank_minutes),
    .alarm         (alarm)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
  endtask

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Hold long enough for the press to land, then release long enough to settle.
  task automatic press(input logic m, input logic i);
    btn_mode = m;
    btn_inc  = i;
    step(6);
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(6);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_hours"},   houres,        0);
    check({pfx, "_minute"},  minute,        0);
    check({pfx, "_seconds"}, seconds,       0);
    check({pfx, "_mode"},    mode,          0);
    check({pfx, "_blank_h"}, blank_hours,   0);
    check({pfx, "_blank_m"}, blank_minutes, 0);
    check({pfx, "_alarm"},   alarm,         0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic s [6];
    bit   found;

    reset    = 1'b1;
    btn_mode = 1'b0;
    btn_inc  = 1'b0;
    step(3);
    check_reset("rst");
    reset = 1'b0;

    // Free run: one second per 4 cycles, one minute after 240.
    step(3);
    check("sec_before_tick", seconds, 0);
    step(1);
    check("sec_first_tick", seconds, 1);
    step(236);
    check("run240_sec", seconds, 0);
    check("run240_min", minute, 1);
    check("run240_hr",  houres, 0);
`ifndef CLOCK_ALARM_EN
    check("alarm_tied", alarm, 0);
`endif

    // A 2-cycle glitch is rejected; a held press lands 6 cycles after the edge.
    btn_mode = 1'b1;
    step(2);
    btn_mode = 1'b0;
    step(10);
    check("glitch_mode", mode, 0);
    btn_mode = 1'b1;
    step(5);
    check("press_mode_early", mode, 0);
    step(1);
    check("press_mode", mode, 1);
    check("enter_set_sec", seconds, 0);
    check("enter_set_min", minute, 1);
    step(4);
    btn_mode = 1'b0;
    step(6);

    // Blink in SET_HOUR: period 4 cycles, minutes never blanked.
    for (int i = 0; i < 6; i++) begin
      s[i] = blank_hours;
      check("blank_m_in_hour", blank_minutes, 0);
      step(1);
    end
    for (int i = 0; i < 4; i++) check("blink_toggle", s[i+2], !s[i]);

    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      if (blank_hours) found = 1'b1;
      else step(1);
    end
    check("blink_high_seen", found, 1);
    reset = 1'b1;
    step(1);
    check_reset("midrst");
    reset = 1'b0;

    // Set 23:59 and run up to the midnight rollover.
    press(1'b1, 1'b0);
    check("set_hour_mode", mode, 1);
    repeat (23) press(1'b0, 1'b1);
    check("hour_23", houres, 23);
    press(1'b0, 1'b1);
    check("hour_wrap", houres, 0);
    repeat (23) press(1'b0, 1'b1);
    press(1'b1, 1'b1);
    check("simul_mode", mode, 2);
    check("simul_hour", houres, 23);
    check("simul_min", minute, 0);
    repeat (59) press(1'b0, 1'b1);
    check("min_59", minute, 59);
    press(1'b0, 1'b1);
    check("min_wrap", minute, 0);
    check("min_wrap_hour", houres, 23);
    repeat (59) press(1'b0, 1'b1);
`ifdef CLOCK_ALARM_EN
    press(1'b1, 1'b0);
    check("set_alarm_mode", mode, 3);
`endif
    btn_mode = 1'b1;
    step(6);
    btn_mode = 1'b0;
    check("back_run", mode, 0);
    check("back_run_sec", seconds, 0);
    step(236);
    check("pre_hr",  houres, 23);
    check("pre_min", minute, 59);
    check("pre_sec", seconds, 59);
    step(3);
    check("hold_sec", seconds, 59);
    step(1);
    check("roll_hr",  houres, 0);
    check("roll_min", minute, 0);
    check("roll_sec", seconds, 0);

`ifdef CLOCK_ALARM_EN
    // Alarm at 0:01, raised on the minute and dismissed by an inc press.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("al_mode", mode, 3);
    check("al_disp_min0", minute, 0);
    press(1'b0, 1'b1);
    check("al_disp_min1", minute, 1);
    check("al_disp_hr", houres, 0);
    btn_mode = 1'b1;
    step(6);
    btn_mode = 1'b0;
    check("al_run", mode, 0);
    check("al_off_start", alarm, 0);
    step(239);
    check("al_min_before", minute, 0);
    check("al_off_before", alarm, 0);
    step(1);
    check("al_min_one", minute, 1);
    check("al_ring", alarm, 1);
    btn_inc = 1'b1;
    step(6);
    btn_inc = 1'b0;
    check("al_dismiss", alarm, 0);
    step(200);
    check("al_still_off", alarm, 0);
    check("al_still_min1", minute, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
